sc_stream_encoder: RTL and testbench

Binary-to-stochastic serial transmitter. It latches an unsigned WIDTH-bit magnitude and emits a unipolar stochastic bitstream of STREAM_LEN = 2^WIDTH-1 bits, one bit per accepted transfer, using a valid/ready handshake. Each bit is produced by comparing a maximal-length LFSR state with the latched value, so the stream has exactly `value` ones. It feeds the serial inputs of the SC arithmetic units (AND-multiply, MUX-add) and their ones-counting decoders.

---
 rtl/sc_pkg.sv | 25 ++
 rtl/sc_lfsr.sv | 46 ++++
 rtl/sc_stream_encoder.sv | 148 ++++++++++++++
 tb/tb_sc_stream_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing stream blocks.
//
// Contents:
//   sc_enc_state_e  - encoder FSM states (IDLE, STREAM, DONE)
//   SC_WIDTH        - default magnitude / LFSR width
//   SC_DEFAULT_TAPS - Fibonacci feedback mask for x^8+x^6+x^5+x^4+1
//   sc_stream_len() - stream length for a given width (2^width - 1)

package sc_pkg;

    localparam int unsigned SC_WIDTH = 8;
    localparam logic [SC_WIDTH-1:0] SC_DEFAULT_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } sc_enc_state_e;

    // A maximal-length LFSR of this width visits every nonzero state once.
    function automatic int unsigned sc_stream_len(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR with synchronous seed load and step enable.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, loads SEED
//   load  - load SEED (priority over step)
//   step  - advance one position: {state[W-2:0], ^(state & TAPS)}
//   state - current LFSR register

module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned       WIDTH = SC_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(SC_DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sc_stream_encoder.sv
// Binary-to-stochastic serial encoder.
//
// Latches an unsigned WIDTH-bit magnitude on start and emits 2^WIDTH-1 bits
// over a valid/ready handshake. Each bit is (lfsr <= value); because the LFSR
// is maximal-length the stream carries exactly `value` ones.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   start      - request a new stream (only honoured in IDLE)
//   value      - magnitude, latched when start is accepted
//   busy       - high in STREAM and DONE
//   bit_out    - current stochastic bit (valid with bit_valid)
//   bit_valid  - high in STREAM
//   out_ready  - consumer accepts bit_out when high with bit_valid
//   ones_count - ones emitted so far (only with SC_ONES_COUNT_EN defined)
//   done       - one-cycle pulse after the last transfer
//
// Build option: define SC_ONES_COUNT_EN to add the ones_count output.

module sc_stream_encoder
    import sc_pkg::*;
#(
    parameter int unsigned       WIDTH     = SC_WIDTH,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(SC_DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             out_ready,
`ifdef SC_ONES_COUNT_EN
    output logic [WIDTH-1:0] ones_count,
`endif
    output logic             done
);

    localparam int unsigned STREAM_LEN = sc_stream_len(WIDTH);
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(STREAM_LEN - 1);

    // An all-zero seed locks the LFSR at zero forever.
    if (LFSR_SEED == '0) begin : g_seed_check
        $error("sc_stream_encoder: LFSR_SEED must be nonzero");
    end

    sc_enc_state_e    state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr_state;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             cmp_bit;
    logic             transfer;

    sc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Outputs depend on registered state only; out_ready never reaches them.
    assign cmp_bit   = (lfsr_state <= value_q);
    assign bit_valid = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign bit_out   = bit_valid & cmp_bit;
    assign transfer  = bit_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d   = value;
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (transfer) begin
                    lfsr_step = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SC_ONES_COUNT_EN
    logic [WIDTH-1:0] ones_q, ones_d;

    always_comb begin
        ones_d = ones_q;
        if (state_q == IDLE && start) begin
            ones_d = '0;
        end else if (transfer && cmp_bit) begin
            ones_d = ones_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Self-checking bench for sc_stream_encoder (WIDTH=8, default seed/taps).

module tb_sc_stream_encoder;

    localparam int STREAM_LEN = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       bit_out;
    logic       bit_valid;
    logic       out_ready;
    logic       done;
`ifdef SC_ONES_COUNT_EN
    logic [7:0] ones_count;
`endif

    sc_stream_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .value      (value),
        .busy       (busy),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .out_ready  (out_ready),
`ifdef SC_ONES_COUNT_EN
        .ones_count (ones_count),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected bit sequence pushed when a start is driven.
    bit         exp_q[$];
    logic [7:0] cur_value;

    typedef struct {
        logic [7:0] value;
        bit         rnd;
        bit         poke;
        int         exp_ones;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference x^8+x^6+x^5+x^4+1 Fibonacci sequence starting at seed 1.
    task automatic push_expected(input logic [7:0] v);
        logic [7:0] s;
        s = 8'h01;
        exp_q.delete();
        for (int i = 0; i < STREAM_LEN; i++) begin
            exp_q.push_back(s <= v);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic accept(input logic [7:0] v);
        value     = v;
        start     = 1'b1;
        cur_value = v;
        push_expected(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int exp_ones, input bit rnd, input bit poke, input bit done_start);
        int  ones = 0;
        int  xfers = 0;
        int  seq_err = 0;
        int  stall_err = 0;
        int  elapsed = 0;
        int  first_bit = -1;
        bit  prev_stall = 1'b0;
        bit  prev_bit = 1'b0;
        bit  got_done = 1'b0;
        bit  e;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (prev_stall && bit_valid && (bit_out != prev_bit)) stall_err++;
            prev_stall = bit_valid && !out_ready;
            prev_bit   = bit_out;
            if (bit_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    seq_err++;
                end else begin
                    e = exp_q.pop_front();
                    if (e != bit_out) seq_err++;
                end
                if (first_bit < 0) first_bit = int'(bit_out);
                ones += int'(bit_out);
                xfers++;
            end
            // Stray starts and value changes mid-stream must be ignored.
            value = 8'($urandom);
            start = poke && (xfers == 50);
            @(negedge clk);
            elapsed++;
        end
        start = 1'b0;
        check("done_seen", int'(got_done), 1);
        check("ones", ones, exp_ones);
        check("transfers", xfers, STREAM_LEN);
        check("bit_seq_errors", seq_err, 0);
        check("stall_hold_errors", stall_err, 0);
        check("first_bit", first_bit, int'(8'h01 <= cur_value));
        if (!rnd) check("start_to_done_edges", elapsed, STREAM_LEN);
`ifdef SC_ONES_COUNT_EN
        check("ones_count_at_done", int'(ones_count), int'(cur_value));
`endif
        if (done_start) begin
            value = 8'h33;
            start = 1'b1;
        end
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{value: 8'h00, rnd: 1'b0, poke: 1'b0, exp_ones: 0};
        vecs[1] = '{value: 8'hFF, rnd: 1'b0, poke: 1'b0, exp_ones: 255};
        vecs[2] = '{value: 8'h01, rnd: 1'b0, poke: 1'b0, exp_ones: 1};
        vecs[3] = '{value: 8'h80, rnd: 1'b0, poke: 1'b0, exp_ones: 128};
        vecs[4] = '{value: 8'hC3, rnd: 1'b1, poke: 1'b0, exp_ones: 195};
        vecs[5] = '{value: 8'h7F, rnd: 1'b0, poke: 1'b1, exp_ones: 127};
        vecs[6] = '{value: 8'hFE, rnd: 1'b1, poke: 1'b1, exp_ones: 254};

        rst       = 1'b1;
        start     = 1'b0;
        value     = 8'h00;
        out_ready = 1'b0;
        cur_value = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            accept(vecs[i].value);
            drain(vecs[i].exp_ones, vecs[i].rnd, vecs[i].poke, 1'b0);
        end

        // Reset after 100 transfers, then a fresh stream.
        accept(8'h55);
        out_ready = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_bit_valid", int'(bit_valid), 0);
        check("midrst_done", int'(done), 0);
`ifdef SC_ONES_COUNT_EN
        check("midrst_ones_count", int'(ones_count), 0);
`endif
        accept(8'h10);
        drain(16, 1'b0, 1'b0, 1'b0);

        // Start held from the DONE cycle: ignored there, accepted in IDLE.
        accept(8'h0F);
        drain(15, 1'b0, 1'b0, 1'b1);
        accept(8'h33);
        check("start_in_idle_accepted", int'(busy), 1);
        drain(51, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
